// File: rtl/demux_1x2.sv
// Stream 1:2 demultiplexer: one valid/ready input steered by in_sel into two one-entry output registers.
// Optional per-output transfer counters (cnt0/cnt1) are built when DEMUX_COUNT_EN is defined.
module demux_1x2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic drain0;
  logic drain1;
  logic load0;
  logic load1;

  // The selected register can take a word when empty or draining this cycle.
  always_comb begin
    drain0   = out0_valid & out0_ready;
    drain1   = out1_valid & out1_ready;
    in_ready = in_sel ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready);
    load0    = in_valid & in_ready & ~in_sel;
    load1    = in_valid & in_ready & in_sel;
  end

  // Load wins over drain so a simultaneous drain+load keeps the register full.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
    end else if (load0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
    end else if (drain0) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (load1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (drain1) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef DEMUX_COUNT_EN
  // Completed output transfers, wrapping silently modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (drain0) cnt0 <= cnt0 + CNT_W'(1);
      if (drain1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x2.sv
// Self-checking bench for demux_1x2: vector table plus hand sequences, with per-output scoreboards.
module tb_demux_1x2;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready = 1'b0;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready = 1'b0;
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
`endif

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNT_W-1:0] m0 = '0;
  logic [CNT_W-1:0] m1 = '0;

  always #5 clk = ~clk;

  demux_1x2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out0_data(out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data(out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt0(cnt0),
    .cnt1(cnt1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Inputs change just after the rising edge; the caller samples at the following falling edge.
  task automatic drive(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic s,
                       input logic r0, input logic r1);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; in_sel = s; out0_ready = r0; out1_ready = r1;
    @(negedge clk);
  endtask

  // Scoreboard: handshakes that will happen at the next rising edge are observed mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m0 = '0;
      m1 = '0;
    end else begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          n_total++;
          $display("FAIL sb0_unexpected: got word 0x%0h expected no word", out0_data);
        end else check("sb0_data", 32'(out0_data), 32'(q0.pop_front()));
        m0 = m0 + CNT_W'(1);
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          n_total++;
          $display("FAIL sb1_unexpected: got word 0x%0h expected no word", out1_data);
        end else check("sb1_data", 32'(out1_data), 32'(q1.pop_front()));
        m1 = m1 + CNT_W'(1);
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else q0.push_back(in_data);
      end
    end
  end

  task automatic check_counts(input string name, input logic [CNT_W-1:0] e0, input logic [CNT_W-1:0] e1);
    check({name, "_model0"}, 32'(m0), 32'(e0));
    check({name, "_model1"}, 32'(m1), 32'(e1));
`ifdef DEMUX_COUNT_EN
    check({name, "_cnt0"}, 32'(cnt0), 32'(e0));
    check({name, "_cnt1"}, 32'(cnt1), 32'(e1));
`endif
  endtask

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             s;
    logic             r0;
    logic             r1;
    logic             exp_rdy;
    logic             exp_v0;
    logic             exp_v1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Backpressure / head-of-line sequence; exp_* describe the state before each edge.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held for two cycles with a valid word presented.
    drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("rst_v0", 32'(out0_valid), 32'd0);
    check("rst_v1", 32'(out1_valid), 32'd0);
    check("rst_d0", 32'(out0_data), 32'd0);
    check("rst_d1", 32'(out1_data), 32'd0);
    check_counts("rst", 8'd0, 8'd0);

    // Basic routing, back to back.
    drive(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1);
    check("route_rdy0", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    check("route_rdy1", 32'(in_ready), 32'd1);
    check("route_v0", 32'(out0_valid), 32'd1);
    check("route_d0", 32'(out0_data), 32'hA5);
    check("route_v1_early", 32'(out1_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("route_v0_gone", 32'(out0_valid), 32'd0);
    check("route_v1", 32'(out1_valid), 32'd1);
    check("route_d1", 32'(out1_data), 32'h3C);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("route_v1_gone", 32'(out1_valid), 32'd0);
    check_counts("route", 8'd1, 8'd1);

    // Backpressure and head-of-line blocking from the table.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].r0, vecs[i].r1);
      check($sformatf("hol%0d_rdy", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      check($sformatf("hol%0d_v0", i), 32'(out0_valid), 32'(vecs[i].exp_v0));
      check($sformatf("hol%0d_v1", i), 32'(out1_valid), 32'(vecs[i].exp_v1));
      if (vecs[i].exp_v0 && !vecs[i].r0)
        check($sformatf("hol%0d_hold0", i), 32'(out0_data), (i < 4) ? 32'h11 : 32'h22);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("hol_end_v0", 32'(out0_valid), 32'd0);
    check("hol_end_v1", 32'(out1_valid), 32'd0);
    check_counts("hol", 8'd3, 8'd2);

    // Simultaneous drain and load: 0x01..0x10 streamed to out0.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b1, 1'b1);
      check($sformatf("stream%0d_rdy", i), 32'(in_ready), 32'd1);
      if (i > 1) begin
        check($sformatf("stream%0d_v0", i), 32'(out0_valid), 32'd1);
        check($sformatf("stream%0d_d0", i), 32'(out0_data), 32'(i - 1));
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("stream_last_v0", 32'(out0_valid), 32'd1);
    check("stream_last_d0", 32'(out0_data), 32'h10);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("stream_end_v0", 32'(out0_valid), 32'd0);
    check_counts("stream", 8'd19, 8'd2);

    // Counter wrap: 257 out1 transfers after a fresh reset.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check_counts("wrap_start", 8'd0, 8'd0);
    for (int i = 0; i < 257; i++) drive(1'b0, 1'b1, 8'(i), 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("wrap_v1", 32'(out1_valid), 32'd0);
    check_counts("wrap", 8'd0, 8'd1);

    // Reset mid-operation with both outputs full and stalled.
    drive(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 8'h88, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("mid_v0", 32'(out0_valid), 32'd1);
    check("mid_v1", 32'(out1_valid), 32'd1);
    check("mid_d0", 32'(out0_data), 32'h77);
    check("mid_d1", 32'(out1_data), 32'h88);
    drive(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    check("mid_rst_rdy", 32'(in_ready), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("mid_after_d0", 32'(out0_data), 32'd0);
    check("mid_after_d1", 32'(out1_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_after%0d_v0", i), 32'(out0_valid), 32'd0);
      check($sformatf("mid_after%0d_v1", i), 32'(out1_valid), 32'd0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    end
    check_counts("mid", 8'd0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_1x2.md
# demux_1x2

Stream 1:2 demultiplexer, the return-direction counterpart of the 2:1 mux. It accepts one WIDTH-bit word per handshake on a single valid/ready input and steers it to one of two valid/ready outputs chosen by `in_sel`. Each output has a one-entry register, so accepted words are held until the downstream consumer takes them. It sits between a single producer and two consumers, for example when fanning training-data samples out to two processing lanes.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `CNT_W`, default 8: width of the per-output transfer counters. Only used when `DEMUX_COUNT_EN` is defined.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `in_data`  input  WIDTH: input word.
- `in_sel`  input  1: destination of the input word. 0 routes to out0, 1 routes to out1.
- `in_valid`  input  1: the input word and `in_sel` are valid.
- `in_ready`  output  1: the demux accepts the input word this cycle.
- `out0_data`  output  WIDTH: word held in the out0 register.
- `out0_valid`  output  1: the out0 register holds a word.
- `out0_ready`  input  1: the out0 consumer accepts the word.
- `out1_data`  output  WIDTH: same as `out0_data`, for out1.
- `out1_valid`  output  1: same as `out0_valid`, for out1.
- `out1_ready`  input  1: same as `out0_ready`, for out1.
- `cnt0`  output  CNT_W: completed out0 transfers. Present only when `DEMUX_COUNT_EN` is defined.
- `cnt1`  output  CNT_W: completed out1 transfers. Present only when `DEMUX_COUNT_EN` is defined.

## Operation
- **Handshake definitions:**
  - Input handshake: `in_valid & in_ready`.
  - Output N handshake: `outN_valid & outN_ready`.
- **Per-output state:**
  - Each output N is one register: `outN_valid` plus `outN_data`.
  - The register is either EMPTY (`outN_valid`=0) or FULL (`outN_valid`=1).
- **Ready logic:**
  - `in_ready = in_sel ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready)`.
  - This path is combinational from `outN_ready` and `in_sel`. There is no path from `in_valid`.
- **Register N next state:**
  - Load when the input handshakes with `in_sel`=N: `outN_data <= in_data`, `outN_valid <= 1`.
  - Otherwise, clear when output N handshakes: `outN_valid <= 0`.
  - Otherwise, hold.
  - `outN_data` changes only on a load.
- **Drain and load in the same cycle:**
  - The register stays FULL and takes the new word.
  - Full throughput is one word per cycle per output.
- **Head-of-line blocking:**
  - If the selected register is FULL and not draining, `in_ready`=0.
  - The input stalls even when the other output is EMPTY.
  - No reordering and no bypass.
- **Upstream rule:** the producer holds `in_data` and `in_sel` stable while `in_valid & ~in_ready`. The demux does not check this.
- **Output stability:** while `outN_valid & ~outN_ready`, `outN_data` is stable.
- **Independence:** out0 and out1 drain independently. Both may hold words at once.
- **Counters (macro on):**
  - `cntN` increments by 1 on each output-N handshake.
  - Arithmetic is modulo 2^CNT_W; it wraps from all-ones to 0 with no flag.
- **Reset:**
  - Takes priority over every handshake on the same edge.
  - `out0_valid` = `out1_valid` = 0, `out0_data` = `out1_data` = 0, `cnt0` = `cnt1` = 0.
  - Words buffered when reset is asserted are discarded.
  - During reset `in_ready` follows the combinational formula. The registers are empty, so `in_ready` reads 1, but no word is captured while `rst`=1.

## Timing
- Latency: input handshake at edge k, then `outN_valid`=1 and `outN_data` valid after edge k. A consumer can take the word at edge k+1.
- Sustained rate is 1 word/cycle when the targeted consumer holds ready high.
- Minimum FULL time is one cycle.
- First accept after reset release: the first edge with `rst`=0.

## Configuration
- `DEMUX_COUNT_EN`:
  - Defined: `cnt0`/`cnt1` ports and counter registers exist, behaving as above.
  - Undefined: the ports and registers are absent. Datapath and handshake behaviour are identical.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with `in_valid`=1, then release → both `outN_valid`=0, both `outN_data`=0, both counters 0.
- Basic routing (WIDTH=8, both readies held 1):
  - Stimulus: 0xA5 with sel=0, then 0x3C with sel=1, on back-to-back cycles.
  - Response: `out0_data`=0xA5 valid one cycle after its accept, then `out1_data`=0x3C one cycle later.
  - Each valid lasts exactly 1 cycle; counters end at `cnt0`=1, `cnt1`=1.
- Backpressure and head-of-line blocking:
  - Stimulus: `out0_ready`=0; send 0x11 (sel=0), then 0x22 (sel=0), then 0x33 (sel=1).
  - Response: 0x11 is held on out0; `in_ready`=0 while 0x22 is presented.
  - 0x33 is not accepted until `out0_ready`=1.
  - Order at the outputs is 0x11, 0x22, 0x33.
- Simultaneous drain and load: `out0_ready`=1 continuously; stream 0x01..0x10 to sel=0 → `out0_valid` stays 1 for 16 cycles with consecutive data; `in_ready` never drops.
- Counter wrap (CNT_W=8): perform 257 out1 transfers → `cnt1`=1 and `cnt0`=0.
- Reset mid-operation:
  - Stimulus: both outputs FULL and stalled; assert `rst` for 1 cycle with `in_valid`=1.
  - Response: both valids 0 and counters 0 afterward; the stalled words never appear at the outputs.
